// File: rtl/disk_host_arbiter_pkg.sv
// Shared encodings for the host-side disk_sr/disk_cr sector channel.
// Also used by the FDC core for its own disk_sr decode.
package disk_host_pkg;

    localparam int unsigned OP_W  = 2;
    localparam int unsigned CHS_W = 16;

    typedef enum logic [1:0] {
        OP_READ   = 2'd0,
        OP_WRITE  = 2'd1,
        OP_SEEK   = 2'd2,
        OP_NEXTID = 2'd3
    } op_t;

    localparam int unsigned SR_ACK     = 16;
    localparam int unsigned SR_RD0     = 17;
    localparam int unsigned SR_RD1     = 18;
    localparam int unsigned SR_WR0     = 20;
    localparam int unsigned SR_WR1     = 21;
    localparam int unsigned SR_NEXTID  = 22;
    localparam int unsigned SR_SEEK_LO = 24;

    localparam int unsigned CR_DONE = 4;
    localparam int unsigned CR_ERR  = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE,
        S_ACK,
        S_WAIT_CLR
    } state_t;

    // Drops every level-type command bit; ack, next-id toggle and address survive.
    function automatic logic [31:0] sr_cmd_clear(input logic [31:0] sr);
        logic [31:0] r;
        r                    = sr;
        r[SR_RD0]            = 1'b0;
        r[SR_RD1]            = 1'b0;
        r[SR_WR0]            = 1'b0;
        r[SR_WR1]            = 1'b0;
        r[SR_SEEK_LO +: 2]   = 2'b00;
        return r;
    endfunction

endpackage

// File: rtl/disk_host_arbiter_if.sv
// Requester-side bundle of the host channel arbiter: two req/done ports packed side by side.
interface disk_host_arbiter_if;
    import disk_host_pkg::*;

    logic [1:0]         req;
    logic [2*OP_W-1:0]  op;
    logic [1:0]         drive;
    logic [2*CHS_W-1:0] chs;
    logic [1:0]         done;
    logic [1:0]         err;
    logic               tout;

    modport master (output req, op, drive, chs, input done, err, tout);
    modport slave  (input req, op, drive, chs, output done, err, tout);
endinterface

// File: rtl/disk_host_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer remembers the last winner and
// only moves when the caller actually takes the grant.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       take,
    output logic       valid,
    output logic       gnt
);

    logic last;

    always_comb begin
        valid = |req;
        if (req == 2'b11) gnt = ~last;
        else              gnt = req[1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n)             last <= 1'b1;
        else if (take && valid) last <= gnt;
    end

endmodule

// File: rtl/disk_host_arbiter.sv
// Shares the host disk_sr/disk_cr sector channel between two requesters:
// command issue, ack-of-ack handshake, round-robin grant and completion timeout.
module disk_host_arbiter
    import disk_host_pkg::*;
#(
    parameter int unsigned TIMEOUT_W  = 24,
    parameter int unsigned TIMEOUT_EN = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    disk_host_arbiter_if.slave    rq,
    output logic                  busy,
    output logic                  grant_id,
    output logic [31:0]           host_sr,
    input  logic                  host_cr_done,
    input  logic                  host_cr_err
);

    localparam logic [TIMEOUT_W-1:0] T_LAST = ~TIMEOUT_W'(1);

    state_t               state;
    op_t                  op_q;
    logic                 drv_q;
    logic [CHS_W-1:0]     chs_q;
    logic [TIMEOUT_W-1:0] tcnt;
    logic [31:0]          sr_clr;
    logic                 arb_take;
    logic                 arb_valid;
    logic                 arb_id;

    assign sr_clr   = sr_cmd_clear(host_sr);
    // A stale host completion from the previous transaction blocks any new grant.
    assign arb_take = (state == S_IDLE) && !host_cr_done;

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (rq.req),
        .take  (arb_take),
        .valid (arb_valid),
        .gnt   (arb_id)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op_q     <= OP_READ;
            drv_q    <= 1'b0;
            chs_q    <= '0;
            tcnt     <= '0;
            host_sr  <= '0;
            busy     <= 1'b0;
            grant_id <= 1'b0;
            rq.done  <= '0;
            rq.err   <= '0;
            rq.tout  <= 1'b0;
        end else begin
            rq.done <= '0;
            rq.err  <= '0;
            rq.tout <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (arb_take && arb_valid) begin
                        grant_id <= arb_id;
                        op_q     <= op_t'(arb_id ? rq.op[3:2] : rq.op[1:0]);
                        drv_q    <= arb_id ? rq.drive[1] : rq.drive[0];
                        chs_q    <= arb_id ? rq.chs[31:16] : rq.chs[15:0];
                        busy     <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    host_sr <= {sr_clr[31:17], 1'b0, chs_q};
                    unique case (op_q)
                        OP_READ: begin
                            host_sr[SR_RD0] <= !drv_q;
                            host_sr[SR_RD1] <= drv_q;
                        end
                        OP_WRITE: begin
                            host_sr[SR_WR0] <= !drv_q;
                            host_sr[SR_WR1] <= drv_q;
                        end
                        OP_SEEK:   host_sr[SR_SEEK_LO +: 2] <= drv_q ? 2'b10 : 2'b01;
                        OP_NEXTID: host_sr[SR_NEXTID] <= ~host_sr[SR_NEXTID];
                        default:   ;
                    endcase
                    tcnt  <= '0;
                    state <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (tcnt != '1) tcnt <= tcnt + 1'b1;
                    // Host completion takes priority over a coincident timeout.
                    if (host_cr_done) begin
                        host_sr           <= sr_clr;
                        host_sr[SR_ACK]   <= 1'b1;
                        rq.done[grant_id] <= 1'b1;
                        rq.err[grant_id]  <= host_cr_err;
                        state             <= S_ACK;
                    end else if (TIMEOUT_EN != 0 && tcnt == T_LAST) begin
                        host_sr           <= sr_clr;
                        rq.done[grant_id] <= 1'b1;
                        rq.err[grant_id]  <= 1'b1;
                        rq.tout           <= 1'b1;
                        state             <= S_WAIT_CLR;
                    end
                end
                S_ACK: state <= S_WAIT_CLR;
                S_WAIT_CLR: begin
                    if (!host_cr_done) begin
                        host_sr[SR_ACK] <= 1'b0;
                        busy            <= 1'b0;
                        state           <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_disk_host_arbiter.sv
// Self-checking bench for disk_host_arbiter: vector table, hand-written corner
// sequences and randomized transactions against a transaction-level model.
module tb_disk_host_arbiter;

    localparam logic [31:0] LEVEL = 32'h0336_0000;
    localparam logic [31:0] ACKB  = 32'h0001_0000;
    localparam logic [31:0] TGLB  = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy;
    logic        grant_id;
    logic [31:0] host_sr;
    logic        host_cr_done;
    logic        host_cr_err;

    int tests = 0;
    int fails = 0;

    // Transaction-level model state: last winner and next-id toggle level.
    int m_last;
    bit m_tgl;

    disk_host_arbiter_if rq_if ();

    disk_host_arbiter #(.TIMEOUT_W(4), .TIMEOUT_EN(1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rq           (rq_if),
        .busy         (busy),
        .grant_id     (grant_id),
        .host_sr      (host_sr),
        .host_cr_done (host_cr_done),
        .host_cr_err  (host_cr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        int          op;
        int          drv;
        logic [15:0] chs;
        bit          cr_err;
        int          delay;
        logic [31:0] exp_sr;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("one_cmd", 32'($countones(host_sr & LEVEL) <= 1), 32'(1));
            chk("done_granted", 32'(rq_if.done & ~(2'(1) << grant_id)), 32'(0));
        end
    end

    task automatic set_fields(input int id, input int op, input int drv, input logic [15:0] chs);
        if (id == 0) begin
            rq_if.op[1:0]    = 2'(op);
            rq_if.drive[0]   = drv[0];
            rq_if.chs[15:0]  = chs;
        end else begin
            rq_if.op[3:2]    = 2'(op);
            rq_if.drive[1]   = drv[0];
            rq_if.chs[31:16] = chs;
        end
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        rq_if.req    = '0;
        rq_if.op     = '0;
        rq_if.drive  = '0;
        rq_if.chs    = '0;
        host_cr_done = 1'b0;
        host_cr_err  = 1'b0;
        step();
        step();
        rst_n  = 1'b1;
        m_last = 1;
        m_tgl  = 1'b0;
        chk("rst_sr", host_sr, 32'h0);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_grant", 32'(grant_id), 32'(0));
        chk("rst_done", 32'({rq_if.done, rq_if.err, rq_if.tout}), 32'(0));
    endtask

    // Called with the DUT idle and the request already driven.
    task automatic run_txn(input int id, input logic [31:0] exp_sr, input bit cr_err,
                           input int delay, input bit keep);
        logic [31:0] idle_sr;
        idle_sr = exp_sr & ~LEVEL;
        step();
        chk("grant_busy", 32'(busy), 32'(1));
        chk("grant_id", 32'(grant_id), id);
        step();
        chk("issue_sr", host_sr, exp_sr);
        for (int c = 0; c < delay && c < 15; c++) begin
            chk("wait_sr", host_sr, exp_sr);
            chk("wait_nodone", 32'(rq_if.done), 32'(0));
            step();
        end
        if (delay >= 15) begin
            chk("to_done", 32'(rq_if.done), 32'(1) << id);
            chk("to_err", 32'(rq_if.err), 32'(1) << id);
            chk("to_tout", 32'(rq_if.tout), 32'(1));
            chk("to_sr", host_sr, idle_sr);
            if (!keep) rq_if.req = '0;
            step();
            chk("to_idle_busy", 32'(busy), 32'(0));
            chk("to_pulse", 32'(rq_if.done), 32'(0));
            chk("to_idle_sr", host_sr, idle_sr);
        end else begin
            host_cr_done = 1'b1;
            host_cr_err  = cr_err;
            step();
            chk("done", 32'(rq_if.done), 32'(1) << id);
            chk("done_err", 32'(rq_if.err), 32'(cr_err) << id);
            chk("done_tout", 32'(rq_if.tout), 32'(0));
            chk("done_sr", host_sr, idle_sr | ACKB);
            if (!keep) rq_if.req = '0;
            step();
            chk("done_pulse", 32'(rq_if.done), 32'(0));
            chk("ack_busy", 32'(busy), 32'(1));
            host_cr_done = 1'b0;
            host_cr_err  = 1'b0;
            step();
            chk("clr_busy", 32'(busy), 32'(0));
            chk("clr_sr", host_sr, idle_sr);
        end
    endtask

    function automatic logic [31:0] model_sr(input int op, input int drv, input logic [15:0] chs);
        logic [31:0] cmd;
        cmd = 0;
        case (op)
            0: cmd = (drv != 0) ? (32'd1 << 18) : (32'd1 << 17);
            1: cmd = (drv != 0) ? (32'd1 << 21) : (32'd1 << 20);
            2: cmd = (drv != 0) ? (32'd1 << 25) : (32'd1 << 24);
            default: m_tgl = ~m_tgl;
        endcase
        return 32'(chs) + cmd + (m_tgl ? TGLB : 32'h0);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 0, 0, 16'h8541, 1'b0,  2, 32'h0002_8541};
        vecs[1] = '{1, 1, 1, 16'h1234, 1'b1,  3, 32'h0020_1234};
        vecs[2] = '{0, 2, 0, 16'h0507, 1'b0, 20, 32'h0100_0507};
        vecs[3] = '{1, 3, 0, 16'h00FF, 1'b0,  0, 32'h0040_00FF};
        vecs[4] = '{0, 0, 1, 16'h7F01, 1'b0,  1, 32'h0044_7F01};
        vecs[5] = '{1, 2, 1, 16'h8000, 1'b1,  5, 32'h0240_8000};
        vecs[6] = '{0, 3, 1, 16'hABCD, 1'b0,  4, 32'h0000_ABCD};
        vecs[7] = '{1, 1, 0, 16'hFFFF, 1'b0, 14, 32'h0010_FFFF};

        do_reset();
        foreach (vecs[i]) begin
            set_fields(vecs[i].id, vecs[i].op, vecs[i].drv, vecs[i].chs);
            rq_if.req = 2'(1 << vecs[i].id);
            run_txn(vecs[i].id, vecs[i].exp_sr, vecs[i].cr_err, vecs[i].delay, 1'b0);
        end

        // Both requesting from reset: grants alternate 0,1,0.
        do_reset();
        set_fields(0, 0, 0, 16'h0101);
        set_fields(1, 0, 1, 16'h0202);
        rq_if.req = 2'b11;
        run_txn(0, 32'h0002_0101, 1'b0, 1, 1'b1);
        run_txn(1, 32'h0004_0202, 1'b0, 2, 1'b1);
        run_txn(0, 32'h0002_0101, 1'b0, 0, 1'b0);

        // Reset during WAIT_DONE of a write.
        do_reset();
        set_fields(0, 1, 0, 16'h0C0D);
        rq_if.req = 2'b01;
        step();
        step();
        chk("rstw_sr", host_sr, 32'h0010_0C0D);
        step();
        step();
        rst_n = 1'b0;
        step();
        chk("rstw_sr0", host_sr, 32'h0);
        chk("rstw_busy", 32'(busy), 32'(0));
        chk("rstw_done", 32'(rq_if.done), 32'(0));
        rst_n = 1'b1;
        run_txn(0, 32'h0010_0C0D, 1'b0, 3, 1'b0);

        // Stale host completion held after ACK while requester 1 waits.
        set_fields(0, 0, 0, 16'h1111);
        set_fields(1, 3, 0, 16'h2222);
        rq_if.req = 2'b01;
        step();
        chk("st_grant0", 32'(grant_id), 32'(0));
        rq_if.req[1] = 1'b1;
        step();
        chk("st_sr0", host_sr, 32'h0002_1111);
        host_cr_done = 1'b1;
        step();
        chk("st_done0", 32'(rq_if.done), 32'(1));
        rq_if.req[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("st_hold_busy", 32'(busy), 32'(1));
            chk("st_hold_gid", 32'(grant_id), 32'(0));
            chk("st_hold_sr", host_sr, 32'h0001_1111);
        end
        host_cr_done = 1'b0;
        step();
        chk("st_idle", 32'(busy), 32'(0));
        chk("st_idle_sr", host_sr, 32'h0000_1111);
        step();
        chk("st_grant1", 32'(busy), 32'(1));
        chk("st_gid1", 32'(grant_id), 32'(1));
        step();
        chk("st_nextid", host_sr, 32'h0040_2222);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("st_tgl_once", host_sr, 32'h0040_2222);
        end
        host_cr_done = 1'b1;
        step();
        chk("st_done1", 32'(rq_if.done), 32'(2));
        chk("st_done1_sr", host_sr, 32'h0041_2222);
        rq_if.req = '0;
        step();
        host_cr_done = 1'b0;
        step();
        chk("st_end", 32'(busy), 32'(0));

        // Stale completion seen directly in IDLE blocks the grant.
        host_cr_done = 1'b1;
        set_fields(0, 0, 0, 16'h1111);
        rq_if.req = 2'b01;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stale_nogrant", 32'(busy), 32'(0));
        end
        host_cr_done = 1'b0;
        run_txn(0, 32'h0042_1111, 1'b0, 1, 1'b0);

        // Randomized transactions.
        do_reset();
        for (int n = 0; n < 40; n++) begin
            int          mask;
            int          win;
            int          ops  [2];
            int          drvs [2];
            logic [15:0] chss [2];
            int          dly;
            bit          e;
            logic [31:0] exp;
            mask = int'($urandom_range(1, 3));
            for (int r = 0; r < 2; r++) begin
                ops[r]  = int'($urandom_range(0, 3));
                drvs[r] = int'($urandom_range(0, 1));
                chss[r] = 16'($urandom);
                set_fields(r, ops[r], drvs[r], chss[r]);
            end
            if (mask == 3) win = (m_last == 0) ? 1 : 0;
            else           win = (mask == 2) ? 1 : 0;
            m_last = win;
            exp = model_sr(ops[win], drvs[win], chss[win]);
            dly = ($urandom_range(0, 7) == 0) ? int'($urandom_range(15, 18))
                                               : int'($urandom_range(0, 14));
            e = 1'($urandom_range(0, 1));
            rq_if.req = 2'(mask);
            run_txn(win, exp, e, dly, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/disk_host_arbiter.md
Name: disk_host_arbiter

Overview:
- Sequences and shares the single host-side sector channel between two requesters, e.g. the FDC and a secondary loader or the second FDC instance. The channel is the disk_sr command word going out and the disk_cr completion bits coming back.
- Owns the full command/ack-of-ack handshake, round-robin arbitration and a completion timeout, so requesters only see a req/done pair.
- Sits between the FDC cores and the top-level disk_sr/disk_cr registers read and written by the host MCU.

Parameters:
- TIMEOUT_W, 24, width of the completion-timeout counter; timeout fires after 2^TIMEOUT_W - 1 cycles in WAIT_DONE.
- TIMEOUT_EN, 1, 0 disables the timeout (wait forever).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- req  in  2  per-requester request level; held high, fields stable, until its done pulse
- op  in  4  per requester 2 bits, {op1,op0}: 0 read, 1 write, 2 seek, 3 next-id
- drive  in  2  per requester drive select (0 = drive A, 1 = drive B)
- chs  in  32  per requester {head[15], cyl[14:8], sector[7:0]}, packed {chs1,chs0}
- done  out  2  one-cycle completion pulse for the granted requester
- err  out  2  valid with done: host error (cr[3]) or timeout
- tout  out  1  valid with done: 1 = completion was a timeout
- busy  out  1  high in any state other than IDLE
- grant_id  out  1  requester currently owning the channel; last owner when idle
- host_sr  out  32  disk_sr image: [7:0] sector, [14:8] cyl, [15] head, [16] ack-of-ack, [17]/[18] read d0/d1, [20]/[21] write d0/d1, [22] next-id toggle, [25:24] seek d1/d0
- host_cr_done  in  1  disk_cr[4], host completion
- host_cr_err  in  1  disk_cr[3], host error

Behaviour:
- Clock is clk; reset rst_n is synchronous, active-low. Reset values: host_sr=0, done=0, err=0, tout=0, busy=0, grant_id=0, state=IDLE, timeout counter=0, last-grant pointer=1, so requester 0 wins the first tie.
- Reset mid-operation aborts silently: no done pulse, all command bits cleared the next cycle.
- FSM states: IDLE, ISSUE, WAIT_DONE, ACK, WAIT_CLR.
- IDLE:
  - If any req is high and host_cr_done=0, grant one requester. Single request: grant it. Both: grant the one that is not the last-granted.
  - Latch op, drive and chs of the winner into holding registers; update grant_id and the pointer; go to ISSUE.
  - If host_cr_done is still high from the previous transaction, do not grant.
- ISSUE (1 cycle):
  - Write host_sr[15:0]=latched chs and clear host_sr[16].
  - Set exactly one command field:
    - read: bit 17 (drive 0) or 18 (drive 1)
    - write: bit 20/21
    - seek: [25:24]=01 (drive 0) or 10 (drive 1)
    - next-id: toggle bit 22; no level bit
  - Clear the timeout counter; go to WAIT_DONE.
- WAIT_DONE:
  - Counter increments each cycle.
  - On host_cr_done=1: clear bits 17,18,20,21,25:24; set bit 16; pulse done[grant_id] with err=host_cr_err, tout=0; go to ACK.
  - Next-id completes on done like the others.
- Timeout: when the counter reaches all-ones with TIMEOUT_EN=1 and host_cr_done still 0:
  - clear the command bits, leave bit 16 at 0;
  - pulse done with err=1, tout=1;
  - go to WAIT_CLR.
  - If done and timeout coincide, done wins (normal completion).
- ACK: go to WAIT_CLR next cycle.
- WAIT_CLR: hold until host_cr_done=0, then clear bit 16 and go to IDLE. The earliest next grant is the following cycle. Address fields [15:0] keep their last value.
- A req dropping after grant is ignored; the transaction completes and done still pulses.
- A req rising during a transaction waits; there is no preemption.
- done is never asserted for a requester that was not granted.
- The counter saturates, with no wrap-around.

Decomposition:
- Shared package disk_host_pkg holds:
  - op encodings (OP_READ, OP_WRITE, OP_SEEK, OP_NEXTID);
  - host_sr bit indices (SR_ACK=16, SR_RD0=17, SR_RD1=18, SR_WR0=20, SR_WR1=21, SR_NEXTID=22, SR_SEEK_LO=24);
  - CR_DONE=4 and CR_ERR=3.
- The FDC core uses the same package for its own disk_sr decode.
- One natural sub-module: rr_arbiter2 (2-way round-robin with pointer update on grant). Everything else stays in the top.

Test Plan:
- Read, requester 0: req[0]=1, op0=0, drive0=0, chs0=0x8541.
  - Required: host_sr[17]=1 and host_sr[15:0]=0x8541 within 2 cycles.
  - Host sets cr_done=1, cr_err=0: next cycle done[0]=1, err[0]=0, host_sr[17]=0, host_sr[16]=1.
  - cr_done=0: bit 16 clears and busy=0.
- Simultaneous req=2'b11 from reset, both reads:
  - Required grant order 0,1,0 over three back-to-back transactions.
  - Never two command bits set at once.
- Write, drive 1, requester 1, host returns cr_err=1 -> host_sr[21] set during WAIT_DONE, done[1]=1 with err[1]=1, tout=0.
- Seek drive 0 with TIMEOUT_W=4 and host silent -> host_sr[25:24]=01, then after 15 WAIT_DONE cycles done pulses with err=1, tout=1, [25:24]=00, bit 16 never set.
- rst_n=0 during WAIT_DONE of a write -> next cycle host_sr=0, busy=0, no done pulse; a fresh req is granted normally after release.
- Stale host_cr_done=1 held after ACK while req[1]=1:
  - Required: no grant until cr_done=0.
  - Then ISSUE within 2 cycles; next-id op toggles bit 22 exactly once.
